// File: rtl/uart_tx_mmio_if.sv
// Memory-mapped bus between the SoC load/store path and the UART transmitter.
// The master drives the select/strobe side and the slave returns registered read data.
interface uart_tx_mmio_if;
  logic        io_sel;
  logic        io_addr;
  logic [31:0] io_wdata;
  logic [3:0]  io_wmask;
  logic        io_rstrb;
  logic [31:0] io_rdata;

  modport master (output io_sel, io_addr, io_wdata, io_wmask, io_rstrb, input io_rdata);
  modport slave  (input io_sel, io_addr, io_wdata, io_wmask, io_rstrb, output io_rdata);
endinterface

// File: rtl/uart_tx_mmio.sv
// Byte-wide MMIO UART transmitter: DATA register pushes into a circular FIFO,
// STATUS register reports BUSY/FULL/EMPTY/OVERFLOW and FIFO count; line is 8N1.
module uart_tx_mmio #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic          clk,
  input  logic          resetn,
  uart_tx_mmio_if.slave bus,
  output logic          tx
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q;
  logic [15:0]   baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   rdata_q;
  logic [31:0]   status;
  logic          wr, rd, full, empty, pop, push;
  logic          unused_bits;

  assign unused_bits = ^{bus.io_wdata[31:8], bus.io_wmask[3:1]};

  always_comb begin
    wr      = bus.io_sel & bus.io_wmask[0] & ~bus.io_addr;
    rd      = bus.io_sel & bus.io_rstrb;
    full    = (count_q == CW'(FIFO_DEPTH));
    empty   = (count_q == '0);
    pop     = (state_q == IDLE) & ~empty;
    // A full FIFO still takes a byte when the transmitter drains one on the same edge.
    push    = wr & (~full | pop);
    count_d = count_q + CW'(push) - CW'(pop);
    ovf_d   = (ovf_q & ~(rd & bus.io_addr)) | (wr & full & ~pop);
    status  = {17'd0, 7'(count_q), 4'd0, ovf_q, empty, full, state_q != IDLE};
  end

  always_ff @(posedge clk) begin
    if (resetn && push) mem_q[wptr_q] <= bus.io_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      baud_q  <= BAUD_RELOAD;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      if (rd)   rdata_q <= bus.io_addr ? status : 32'd0;
      // Line level trails the state by one edge so every bit lasts a full baud period.
      tx_q <= (state_q == START) ? 1'b0 : (state_q == DATA) ? shift_q[0] : 1'b1;
      case (state_q)
        IDLE: begin
          if (pop) begin
            shift_q <= mem_q[rptr_q];
            baud_q  <= BAUD_RELOAD;
            state_q <= START;
          end
        end
        START: begin
          if (baud_q == '0) begin
            baud_q  <= BAUD_RELOAD;
            bit_q   <= '0;
            state_q <= DATA;
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        DATA: begin
          if (baud_q == '0) begin
            baud_q  <= BAUD_RELOAD;
            shift_q <= shift_q >> 1;
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= STOP;
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        STOP: begin
          if (baud_q == '0) begin
            baud_q  <= BAUD_RELOAD;
            state_q <= IDLE;
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx           = tx_q;
  assign bus.io_rdata = rdata_q;
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: register vector table, directed frame/overflow/reset/wrap
// sequences, and random bus traffic scored against a FIFO-and-frame-time model.
module tb_uart_tx_mmio;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic tx;

  uart_tx_mmio_if bus();

  uart_tx_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .tx(tx)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, rst_edges = 0;

  // Reference model: queued bytes, transmitter busy time left, sticky overflow, read data.
  logic [7:0]  m_q[$];
  logic [7:0]  m_sent[$];
  int          m_start[$];
  int          m_busy = 0;
  bit          m_ovf = 1'b0;
  logic [31:0] m_rdata = '0;

  logic [7:0]  rxq[$];
  int          rx_start[$];

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] m_status();
    return {17'd0, 7'(m_q.size()), 4'd0, m_ovf, m_q.size() == 0, m_q.size() == DEPTH, m_busy > 0};
  endfunction

  task automatic model_step();
    bit wr, rd, full, pop;
    logic [7:0] b;
    if (!resetn) begin
      rst_edges++;
      if (m_busy > 0) begin
        m_sent.delete(m_sent.size() - 1);
        m_start.delete(m_start.size() - 1);
      end
      m_q.delete();
      m_busy = 0; m_ovf = 1'b0; m_rdata = '0;
      return;
    end
    wr   = bus.io_sel && bus.io_wmask[0] && !bus.io_addr;
    rd   = bus.io_sel && bus.io_rstrb;
    full = m_q.size() == DEPTH;
    pop  = m_busy == 0 && m_q.size() > 0;
    if (rd) m_rdata = bus.io_addr ? m_status() : 32'd0;
    m_ovf = (m_ovf && !(rd && bus.io_addr)) || (wr && full && !pop);
    if (pop) begin
      b = m_q.pop_front();
      m_sent.push_back(b);
      m_start.push_back(cyc + 1);
      m_busy = FRAME;
    end else if (m_busy > 0) begin
      m_busy--;
    end
    if (wr && (!full || pop)) m_q.push_back(bus.io_wdata[7:0]);
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    @(negedge clk);
  endtask

  task automatic drive(bit sel, bit addr, logic [31:0] wd, logic [3:0] wm, bit rs);
    bus.io_sel = sel; bus.io_addr = addr; bus.io_wdata = wd; bus.io_wmask = wm; bus.io_rstrb = rs;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 32'd0, 4'd0, 1'b0);
  endtask

  task automatic wr_byte(logic [7:0] b);
    drive(1'b1, 1'b0, {24'hABCDEF, b}, 4'h1, 1'b0);
    tick();
    idle_in();
  endtask

  task automatic rd_status();
    drive(1'b1, 1'b1, 32'd0, 4'd0, 1'b1);
    tick();
    idle_in();
  endtask

  task automatic run_to(int c);
    idle_in();
    while (cyc < c) tick();
  endtask

  task automatic drain();
    int n = 0;
    idle_in();
    while ((m_busy > 0 || m_q.size() > 0) && n < 2000) begin
      tick();
      n++;
    end
    repeat (3) tick();
    if (n >= 2000) check("drain_timeout", 32'd1, 32'd0);
  endtask

  // Serial monitor: samples every cycle of a frame so bit lengths are checked exactly.
  logic [39:0] mon_s;
  int          mon_t0, mon_r0;
  bit          mon_ok, mon_abort;
  logic [7:0]  mon_b;
  initial begin
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        mon_t0 = cyc; mon_r0 = rst_edges; mon_s = '0; mon_abort = 1'b0;
        for (int k = 1; k < 40; k++) begin
          @(negedge clk);
          if (rst_edges != mon_r0) begin
            mon_abort = 1'b1;
            break;
          end
          mon_s[k] = tx;
        end
        if (!mon_abort) begin
          mon_ok = 1'b1;
          for (int k = 0; k < 40; k++) if (mon_s[k] !== mon_s[(k / 4) * 4]) mon_ok = 1'b0;
          if (mon_s[0] !== 1'b0 || mon_s[36] !== 1'b1) mon_ok = 1'b0;
          for (int i = 0; i < 8; i++) mon_b[i] = mon_s[4 + 4 * i];
          check("frame_shape", 32'(mon_ok), 32'd1);
          rxq.push_back(mon_b);
          rx_start.push_back(mon_t0);
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          sel;
    bit          addr;
    logic [31:0] wd;
    logic [3:0]  wm;
    bit          rs;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[13];

  initial begin
    int n0, base, lows;
    int tx_off[8];
    bit tx_exp[8];
    bit sel, addr, rs;

    tbl[0]  = '{1'b1, 1'b1, 32'h0,  4'h0, 1'b1, 32'h4};
    tbl[1]  = '{1'b1, 1'b0, 32'h0,  4'h0, 1'b1, 32'h0};
    tbl[2]  = '{1'b0, 1'b1, 32'h0,  4'h0, 1'b1, 32'h0};
    tbl[3]  = '{1'b1, 1'b1, 32'h77, 4'hF, 1'b0, 32'h0};
    tbl[4]  = '{1'b1, 1'b1, 32'h0,  4'h0, 1'b1, 32'h4};
    tbl[5]  = '{1'b1, 1'b0, 32'h99, 4'hE, 1'b0, 32'h4};
    tbl[6]  = '{1'b1, 1'b1, 32'h0,  4'h0, 1'b1, 32'h4};
    tbl[7]  = '{1'b0, 1'b0, 32'h42, 4'h1, 1'b0, 32'h4};
    tbl[8]  = '{1'b1, 1'b1, 32'h0,  4'h0, 1'b1, 32'h4};
    tbl[9]  = '{1'b1, 1'b0, 32'h5A, 4'h1, 1'b1, 32'h0};
    tbl[10] = '{1'b1, 1'b1, 32'h0,  4'h0, 1'b1, 32'h100};
    tbl[11] = '{1'b1, 1'b1, 32'h0,  4'h0, 1'b1, 32'h5};
    tbl[12] = '{1'b1, 1'b0, 32'h0,  4'h0, 1'b1, 32'h0};

    // Reset with a write pending: the write must not land.
    resetn = 1'b0;
    drive(1'b1, 1'b0, 32'hEE, 4'h1, 1'b0);
    repeat (3) tick();
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_rdata", bus.io_rdata, 32'd0);
    resetn = 1'b1;
    idle_in();
    tick();

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].sel, tbl[i].addr, tbl[i].wd, tbl[i].wm, tbl[i].rs);
      tick();
      check($sformatf("vec%0d", i), bus.io_rdata, tbl[i].exp);
    end
    drain();

    // Single 0x55: start at N+2, 4 cycles per bit, idle by N+42.
    n0 = cyc + 1;
    wr_byte(8'h55);
    tx_off = '{1, 2, 5, 6, 10, 37, 38, 41};
    tx_exp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      run_to(n0 + tx_off[i]);
      check($sformatf("tx_n+%0d", tx_off[i]), 32'(tx), 32'(tx_exp[i]));
      if (i == 6) begin
        run_to(n0 + 40);
        rd_status();
        check("busy_n+41", bus.io_rdata, 32'h5);
      end
    end
    run_to(n0 + 42);
    rd_status();
    check("idle_n+43", bus.io_rdata, 32'h4);
    check("single_byte", 32'(rxq[rxq.size() - 1]), 32'h55);
    check("single_start", 32'(rx_start[rx_start.size() - 1]), 32'(n0 + 2));
    drain();

    // Overflow: 6 back-to-back writes, one popped, four queued, sixth dropped.
    base = rxq.size();
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, 1'b0, 32'(i), 4'h1, 1'b0);
      tick();
    end
    rd_status();
    check("ovf_status1", bus.io_rdata, 32'h40B);
    rd_status();
    check("ovf_status2", bus.io_rdata, 32'h403);
    drain();
    check("ovf_rx_count", 32'(rxq.size()), 32'(base + 5));
    for (int i = 0; i < 5; i++)
      if (base + i < rxq.size()) check($sformatf("ovf_rx%0d", i), 32'(rxq[base + i]), 32'(i + 1));

    // Back-to-back frames are 41 cycles apart.
    base = rxq.size();
    wr_byte(8'hA5);
    wr_byte(8'h3C);
    drain();
    check("b2b_count", 32'(rxq.size()), 32'(base + 2));
    if (rxq.size() >= base + 2) begin
      check("b2b_gap", 32'(rx_start[base + 1] - rx_start[base]), 32'd41);
      check("b2b_byte0", 32'(rxq[base]), 32'hA5);
      check("b2b_byte1", 32'(rxq[base + 1]), 32'h3C);
    end

    // Reset during data bit 3 of 0xFF with two bytes queued.
    n0 = cyc + 1;
    wr_byte(8'hFF);
    wr_byte(8'h11);
    wr_byte(8'h22);
    run_to(n0 + 18);
    resetn = 1'b0;
    drive(1'b1, 1'b0, 32'h33, 4'h1, 1'b0);
    tick();
    check("midrst_tx", 32'(tx), 32'd1);
    resetn = 1'b1;
    idle_in();
    tick();
    rd_status();
    check("midrst_status", bus.io_rdata, 32'h4);
    base = rxq.size();
    lows = 0;
    repeat (100) begin
      tick();
      if (tx !== 1'b1) lows++;
    end
    check("midrst_tx_low_cycles", 32'(lows), 32'd0);
    check("midrst_no_frames", 32'(rxq.size()), 32'(base));

    // Pointer wrap: 10 bytes in bursts of 3.
    base = rxq.size();
    for (int k = 0; k < 10; k++) begin
      wr_byte(8'h10 + 8'(k));
      if (k % 3 == 2 || k == 9) drain();
    end
    rd_status();
    check("wrap_status", bus.io_rdata, 32'h4);
    check("wrap_count", 32'(rxq.size()), 32'(base + 10));
    for (int k = 0; k < 10; k++)
      if (base + k < rxq.size()) check($sformatf("wrap_rx%0d", k), 32'(rxq[base + k]), 32'h10 + 32'(k));

    // Random bus traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      sel  = ($urandom_range(0, 99) < 30);
      addr = 1'($urandom_range(0, 1));
      rs   = 1'($urandom_range(0, 1));
      drive(sel, addr, $urandom, 4'($urandom), rs);
      tick();
      if (sel && rs) check("rand_rdata", bus.io_rdata, m_rdata);
    end
    drain();
    rd_status();
    check("final_status", bus.io_rdata, m_rdata);

    check("rx_total", 32'(rxq.size()), 32'(m_sent.size()));
    for (int i = 0; i < rxq.size() && i < m_sent.size(); i++) begin
      check($sformatf("rx_byte%0d", i), 32'(rxq[i]), 32'(m_sent[i]));
      check($sformatf("rx_start%0d", i), 32'(rx_start[i]), 32'(m_start[i]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
